// File: rtl/tw4_cmul.sv
// Radix-4 FFT twiddle-multiply stage: addresses the 4-entry twiddle ROM from a sample
// counter and multiplies each streamed complex sample by the Q2.8 twiddle, rounded and saturated.
module tw4_cmul #(
    parameter int DW      = 13,
    parameter int TW      = 10,
    parameter int SEG_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] din_re,
    input  logic signed [DW-1:0] din_im,
    output logic [1:0]           tw_addr,
    input  logic signed [TW-1:0] tw_re,
    input  logic signed [TW-1:0] tw_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] dout_re,
    output logic signed [DW-1:0] dout_im,
    output logic                 dout_last
);

    localparam int CW   = $clog2(4 * SEG_LEN);
    localparam int PW   = DW + TW + 1;
    localparam int FRAC = TW - 2;

    localparam logic signed [PW-1:0] RND     = PW'(2 ** (FRAC - 1));
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DW - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (DW - 1)));

    // Round half up on the Q2.8 fraction, then clamp into the output range.
    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] t;
        t = v + RND;
        t = t >>> FRAC;
        if (t > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (t < SAT_MIN)
            return SAT_MIN[DW-1:0];
        else
            return t[DW-1:0];
    endfunction

    logic [CW-1:0]         r_cnt;
    logic                  w_en;
    logic                  w_acc;

    logic                  r_vld_p1;
    logic                  r_last_p1;
    logic signed [DW-1:0]  r_a_re_p1;
    logic signed [DW-1:0]  r_a_im_p1;
    logic signed [TW-1:0]  r_w_re_p1;
    logic signed [TW-1:0]  r_w_im_p1;

    logic                  r_vld_p2;
    logic                  r_last_p2;
    logic signed [DW-1:0]  r_dout_re_p2;
    logic signed [DW-1:0]  r_dout_im_p2;

    logic signed [PW-1:0]  w_are;
    logic signed [PW-1:0]  w_aim;
    logic signed [PW-1:0]  w_wre;
    logic signed [PW-1:0]  w_wim;
    logic signed [PW-1:0]  w_pr;
    logic signed [PW-1:0]  w_pi;

    assign w_en     = !r_vld_p2 || out_ready;
    assign w_acc    = in_valid && w_en;
    assign in_ready = w_en;
    assign tw_addr  = r_cnt[CW-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_acc)
            r_cnt <= r_cnt + CW'(1);
    end

    // ---- stage p1: capture sample, twiddle and block-end flag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1  <= in_valid;
            r_last_p1 <= in_valid && (&r_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_a_re_p1 <= din_re;
            r_a_im_p1 <= din_im;
            r_w_re_p1 <= tw_re;
            r_w_im_p1 <= tw_im;
        end
    end

    // ---- stage p2: full-precision complex product, round, saturate ----
    assign w_are = PW'(r_a_re_p1);
    assign w_aim = PW'(r_a_im_p1);
    assign w_wre = PW'(r_w_re_p1);
    assign w_wim = PW'(r_w_im_p1);
    assign w_pr  = w_are * w_wre - w_aim * w_wim;
    assign w_pi  = w_are * w_wim + w_aim * w_wre;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2     <= 1'b0;
            r_last_p2    <= 1'b0;
            r_dout_re_p2 <= '0;
            r_dout_im_p2 <= '0;
        end else if (w_en) begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            if (r_vld_p1) begin
                r_dout_re_p2 <= rnd_sat(w_pr);
                r_dout_im_p2 <= rnd_sat(w_pi);
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign dout_last = r_last_p2;
    assign dout_re   = r_dout_re_p2;
    assign dout_im   = r_dout_im_p2;

endmodule

// File: tb/tb_tw4_cmul.sv
// Directed bench for tw4_cmul: twiddle ROM model, output capture, per-scenario tasks.
module tb_tw4_cmul;

    localparam int DW  = 13;
    localparam int TW  = 10;
    localparam int SEG = 16;
    localparam logic signed [TW-1:0] ONE  = 10'sd256;
    localparam logic signed [TW-1:0] MONE = -10'sd256;
    localparam logic signed [TW-1:0] ZERO = 10'sd0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] din_re;
    logic signed [DW-1:0] din_im;
    logic [1:0]           tw_addr;
    logic signed [TW-1:0] tw_re;
    logic signed [TW-1:0] tw_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] dout_re;
    logic signed [DW-1:0] dout_im;
    logic                 dout_last;

    logic                 force_tw;
    logic signed [TW-1:0] f_re;
    logic signed [TW-1:0] f_im;

    int total = 0;
    int bad   = 0;

    tw4_cmul #(.DW(DW), .TW(TW), .SEG_LEN(SEG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_re(din_re), .din_im(din_im),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_re(dout_re), .dout_im(dout_im), .dout_last(dout_last)
    );

    // Twiddle ROM: addresses 0..2 hold +1.0, address 3 holds -1.0j
    always_comb begin
        if (force_tw) begin
            tw_re = f_re;
            tw_im = f_im;
        end else if (tw_addr == 2'd3) begin
            tw_re = ZERO;
            tw_im = MONE;
        end else begin
            tw_re = ONE;
            tw_im = ZERO;
        end
    end

    logic signed [DW-1:0] cap_re[$];
    logic signed [DW-1:0] cap_im[$];
    logic                 cap_last[$];
    logic [1:0]           acc_addr[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                cap_re.push_back(dout_re);
                cap_im.push_back(dout_im);
                cap_last.push_back(dout_last);
            end
            if (in_valid && in_ready)
                acc_addr.push_back(tw_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams n samples din = (bre + k*sre, bim + k*sim); out_ready low during the stall window
    task automatic run(input int n, input int bre, input int bim, input int sre, input int sim,
                       input int stall_at, input int stall_len, input bit drain,
                       output int max_inf, output bit hold_ok, output bit ready_low);
        int sent = 0;
        int cyc = 0;
        int start_cap = cap_re.size();
        int inf;
        logic signed [DW-1:0] hre = '0;
        logic signed [DW-1:0] him = '0;
        max_inf = 0;
        hold_ok = 1'b1;
        ready_low = 1'b1;
        while ((sent < n || (drain && (cap_re.size() - start_cap) < n)) && cyc < n + 300) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = (sent < n);
            din_re    = DW'(bre + sent * sre);
            din_im    = DW'(bim + sent * sim);
            #1;
            if (!out_ready && cyc > stall_at && (dout_re !== hre || dout_im !== him))
                hold_ok = 1'b0;
            hre = dout_re;
            him = dout_im;
            if (cyc == stall_at + stall_len - 1 && in_ready)
                ready_low = 1'b0;
            inf = sent - (cap_re.size() - start_cap);
            if (inf > max_inf)
                max_inf = inf;
            if (in_valid && in_ready)
                sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din_re = '0;
        din_im = '0;
        force_tw = 1'b0;
        f_re = ZERO;
        f_im = ZERO;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || dout_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: out_valid=%b dout_last=%b, required 0 0", out_valid, dout_last);
        end
        total++;
        if (dout_re !== 13'sd0 || dout_im !== 13'sd0) begin
            bad++;
            $display("FAIL reset_data: dout=(%0d,%0d), required (0,0)", dout_re, dout_im);
        end
        total++;
        if (tw_addr !== 2'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: tw_addr=%0d in_ready=%b, required 0 1", tw_addr, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        in_valid = 1'b1;
        din_re = 13'sd100;
        din_im = -13'sd50;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_1: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || dout_re !== 13'sd100 || dout_im !== -13'sd50) begin
            bad++;
            $display("FAIL latency_2: out_valid=%b dout=(%0d,%0d), required 1 (100,-50)",
                     out_valid, dout_re, dout_im);
        end
    endtask

    task automatic test_stream();
        int s0, a0, got, mi;
        bit ho, rl;
        logic signed [DW-1:0] er, ei;
        pulse_reset();
        s0 = cap_re.size();
        a0 = acc_addr.size();
        run(128, 100, -50, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        got = cap_re.size() - s0;
        total++;
        if (got != 128 || acc_addr.size() - a0 != 128) begin
            bad++;
            $display("FAIL stream_count: outputs=%0d accepts=%0d, required 128 128",
                     got, acc_addr.size() - a0);
        end
        for (int i = 0; i < got && i < 128; i++) begin
            er = ((i % 64) / SEG == 3) ? -13'sd50 : 13'sd100;
            ei = ((i % 64) / SEG == 3) ? -13'sd100 : -13'sd50;
            total++;
            if (cap_re[s0+i] !== er || cap_im[s0+i] !== ei) begin
                bad++;
                $display("FAIL stream_data[%0d]: got (%0d,%0d), required (%0d,%0d)",
                         i, cap_re[s0+i], cap_im[s0+i], er, ei);
            end
            total++;
            if (cap_last[s0+i] !== (i % 64 == 63)) begin
                bad++;
                $display("FAIL stream_last[%0d]: got %b, required %b", i, cap_last[s0+i], (i % 64 == 63));
            end
            total++;
            if (acc_addr[a0+i] !== 2'((i % 64) / SEG)) begin
                bad++;
                $display("FAIL stream_addr[%0d]: got %0d, required %0d", i, acc_addr[a0+i], (i % 64) / SEG);
            end
        end
    endtask

    task automatic test_saturation();
        int s0, mi;
        bit ho, rl;
        pulse_reset();
        force_tw = 1'b1;
        f_re = ZERO;
        f_im = MONE;
        s0 = cap_re.size();
        run(1, -4096, 0, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== 13'sd0 || cap_im[s0] !== 13'sd4095) begin
            bad++;
            $display("FAIL sat_pos: got (%0d,%0d), required (0,4095)", cap_re[s0], cap_im[s0]);
        end
        s0 = cap_re.size();
        run(1, -4096, -4096, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== -13'sd4096 || cap_im[s0] !== 13'sd4095) begin
            bad++;
            $display("FAIL sat_both: got (%0d,%0d), required (-4096,4095)", cap_re[s0], cap_im[s0]);
        end
        f_re = ONE;
        f_im = ONE;
        s0 = cap_re.size();
        run(1, -4096, -4096, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== 13'sd0 || cap_im[s0] !== -13'sd4096) begin
            bad++;
            $display("FAIL sat_neg: got (%0d,%0d), required (0,-4096)", cap_re[s0], cap_im[s0]);
        end
        force_tw = 1'b0;
    endtask

    task automatic test_rounding();
        int s0, mi;
        bit ho, rl;
        force_tw = 1'b1;
        f_re = 10'sd181;
        f_im = 10'sd181;
        s0 = cap_re.size();
        run(1, 1, 0, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== 13'sd1 || cap_im[s0] !== 13'sd1) begin
            bad++;
            $display("FAIL round_pos: got (%0d,%0d), required (1,1)", cap_re[s0], cap_im[s0]);
        end
        s0 = cap_re.size();
        run(1, -1, 0, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== -13'sd1 || cap_im[s0] !== -13'sd1) begin
            bad++;
            $display("FAIL round_neg: got (%0d,%0d), required (-1,-1)", cap_re[s0], cap_im[s0]);
        end
        s0 = cap_re.size();
        run(1, 0, 1, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        total++;
        if (cap_re.size() != s0 + 1 || cap_re[s0] !== -13'sd1 || cap_im[s0] !== 13'sd1) begin
            bad++;
            $display("FAIL round_mix: got (%0d,%0d), required (-1,1)", cap_re[s0], cap_im[s0]);
        end
        force_tw = 1'b0;
    endtask

    task automatic test_backpressure();
        int s0, a0, got, mi;
        bit ho, rl;
        logic signed [DW-1:0] xr, xi, er, ei;
        pulse_reset();
        s0 = cap_re.size();
        a0 = acc_addr.size();
        run(64, -100, 50, 7, -3, 20, 5, 1'b1, mi, ho, rl);
        got = cap_re.size() - s0;
        total++;
        if (mi > 2) begin
            bad++;
            $display("FAIL bp_inflight: max in flight %0d, required at most 2", mi);
        end
        total++;
        if (rl !== 1'b1) begin
            bad++;
            $display("FAIL bp_in_ready: in_ready high late in stall, required 0");
        end
        total++;
        if (ho !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: dout changed while stalled, required stable");
        end
        total++;
        if (got != 64 || acc_addr.size() - a0 != 64) begin
            bad++;
            $display("FAIL bp_count: outputs=%0d accepts=%0d, required 64 64", got, acc_addr.size() - a0);
        end
        for (int i = 0; i < got && i < 64; i++) begin
            xr = DW'(-100 + 7 * i);
            xi = DW'(50 - 3 * i);
            er = (i / SEG == 3) ? xi : xr;
            ei = (i / SEG == 3) ? -xr : xi;
            total++;
            if (cap_re[s0+i] !== er || cap_im[s0+i] !== ei || cap_last[s0+i] !== (i == 63)
                || acc_addr[a0+i] !== 2'(i / SEG)) begin
                bad++;
                $display("FAIL bp_sample[%0d]: got (%0d,%0d) last=%b addr=%0d, required (%0d,%0d) last=%b addr=%0d",
                         i, cap_re[s0+i], cap_im[s0+i], cap_last[s0+i], acc_addr[a0+i],
                         er, ei, (i == 63), i / SEG);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0, a0, got, mi;
        bit ho, rl;
        logic signed [DW-1:0] er, ei;
        pulse_reset();
        run(20, 100, -50, 0, 0, 100000, 0, 1'b0, mi, ho, rl);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || tw_addr !== 2'd0) begin
            bad++;
            $display("FAIL midrst_state: out_valid=%b tw_addr=%0d, required 0 0", out_valid, tw_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        s0 = cap_re.size();
        a0 = acc_addr.size();
        run(64, 100, -50, 0, 0, 100000, 0, 1'b1, mi, ho, rl);
        got = cap_re.size() - s0;
        total++;
        if (got != 64 || acc_addr.size() - a0 != 64) begin
            bad++;
            $display("FAIL midrst_count: outputs=%0d accepts=%0d, required 64 64", got, acc_addr.size() - a0);
        end
        for (int i = 0; i < got && i < 64; i++) begin
            er = (i / SEG == 3) ? -13'sd50 : 13'sd100;
            ei = (i / SEG == 3) ? -13'sd100 : -13'sd50;
            total++;
            if (cap_re[s0+i] !== er || cap_im[s0+i] !== ei || cap_last[s0+i] !== (i == 63)
                || acc_addr[a0+i] !== 2'(i / SEG)) begin
                bad++;
                $display("FAIL midrst_sample[%0d]: got (%0d,%0d) last=%b addr=%0d, required (%0d,%0d) last=%b addr=%0d",
                         i, cap_re[s0+i], cap_im[s0+i], cap_last[s0+i], acc_addr[a0+i],
                         er, ei, (i == 63), i / SEG);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
